// File: rtl/stop_watch_ctrl.sv
// Stopwatch mode sequencer: sync + sample-debounce + edge detect on two buttons, 5-state Moore FSM.
// Internal press pulse to outputs in 1 cycle; raw press to pulse at most 2*DEB_CNT+3 cycles; no backpressure.
module stop_watch_ctrl #(
  parameter int DEB_CNT = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       run_en,
  output logic       clear,
  output logic       lap_load,
  output logic       disp_lap,
  output logic [2:0] state,
  output logic [1:0] led
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    LAP_RUN   = 3'd3,
    LAP_PAUSE = 3'd4
  } st_t;

  logic [CW-1:0] tmr;
  logic          tick;
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    press;   // bit 0: p_start, bit 1: p_lap
  logic          p_start;
  logic          p_lap;

  st_t  st_q;
  st_t  st_d;
  logic clr_d;
  logic ld_d;

  assign tick    = (tmr == CW'(DEB_CNT - 1));
  assign btn_raw = {btn_lap, btn_start};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr   <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      tmr   <= tick ? '0 : tmr + 1'b1;
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only once two consecutive sample ticks agree on it.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [1:0] hist;
    logic       deb;
    logic       deb_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hist  <= '0;
        deb   <= 1'b0;
        deb_q <= 1'b0;
      end else begin
        if (tick) begin
          hist <= {hist[0], sync2[i]};
        end
        if (hist[1] == hist[0]) begin
          deb <= hist[0];
        end
        deb_q <= deb;
      end
    end

    assign press[i] = deb & ~deb_q;
  end

  assign p_start = press[0];
  assign p_lap   = press[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= IDLE;
      clear    <= 1'b0;
      lap_load <= 1'b0;
    end else begin
      st_q     <= st_d;
      clear    <= clr_d;
      lap_load <= ld_d;
    end
  end

  // p_start is tested first everywhere, so it wins over a coincident p_lap.
  always_comb begin
    st_d  = st_q;
    clr_d = 1'b0;
    ld_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (p_start) st_d = RUN;
      end
      RUN: begin
        if (p_start) begin
          st_d = PAUSE;
        end else if (p_lap) begin
          st_d = LAP_RUN;
          ld_d = 1'b1;
        end
      end
      PAUSE: begin
        if (p_start) begin
          st_d = RUN;
        end else if (p_lap) begin
          st_d  = IDLE;
          clr_d = 1'b1;
        end
      end
      LAP_RUN: begin
        if (p_start)    st_d = LAP_PAUSE;
        else if (p_lap) st_d = RUN;
      end
      LAP_PAUSE: begin
        if (p_start)    st_d = LAP_RUN;
        else if (p_lap) st_d = PAUSE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign run_en   = (st_q == RUN) || (st_q == LAP_RUN);
  assign disp_lap = (st_q == LAP_RUN) || (st_q == LAP_PAUSE);
  assign state    = st_q;
  assign led      = {disp_lap, run_en};

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Scoreboard bench for stop_watch_ctrl with DEB_CNT=4: expected mode events queued per press, popped on output change.
module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       run_en;
  logic       clear;
  logic       lap_load;
  logic       disp_lap;
  logic [2:0] state;
  logic [1:0] led;

  typedef struct {
    logic [2:0] st;
    logic       run;
    logic       disp;
    logic       clr;
    logic       ld;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] prev_st = 3'd0;

  stop_watch_ctrl #(.DEB_CNT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .run_en    (run_en),
    .clear     (clear),
    .lap_load  (lap_load),
    .disp_lap  (disp_lap),
    .state     (state),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic [2:0] st, input logic clr, input logic ld);
    exp_t e;
    e.st   = st;
    e.run  = (st == 3'd1) || (st == 3'd3);
    e.disp = (st == 3'd3) || (st == 3'd4);
    e.clr  = clr;
    e.ld   = ld;
    exp_q.push_back(e);
  endtask

  // Any state change or pulse is an event; it must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (state !== prev_st || clear || lap_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_evt_state", state, prev_st);
          chk("unexpected_evt_q", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("state", state, e.st);
          chk("run_en", run_en, e.run);
          chk("disp_lap", disp_lap, e.disp);
          chk("clear", clear, e.clr);
          chk("lap_load", lap_load, e.ld);
          chk("led", led, {e.disp, e.run});
        end
      end
      if (clear && lap_load) chk("pulse_overlap", 1, 0);
    end
    prev_st = state;
  end

  task automatic press(input bit s, input bit l, input int hold);
    @(negedge clk);
    btn_start = s;
    btn_lap   = l;
    repeat (hold) @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (24) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_run_en"}, run_en, 0);
    chk({tag, "_disp_lap"}, disp_lap, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_lap_load"}, lap_load, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    chk_reset_outputs("rst");
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", state, 0);

    // Lap in IDLE does nothing.
    press(1'b0, 1'b1, 12);
    chk("idle_lap", state, 0);

    // Glitches: 1-cycle and 3-cycle highs never span two ticks.
    for (int k = 0; k < 4; k++) begin
      repeat (k) @(negedge clk);
      press(1'b1, 1'b0, 1);
      press(1'b1, 1'b0, 3);
    end
    chk("glitch", state, 0);

    expect_evt(3'd1, 1'b0, 1'b0); press(1'b1, 1'b0, 12);
    expect_evt(3'd2, 1'b0, 1'b0); press(1'b1, 1'b0, 12);
    expect_evt(3'd1, 1'b0, 1'b0); press(1'b1, 1'b0, 12);
    expect_evt(3'd3, 1'b0, 1'b1); press(1'b0, 1'b1, 12);
    expect_evt(3'd4, 1'b0, 1'b0); press(1'b1, 1'b0, 12);
    expect_evt(3'd2, 1'b0, 1'b0); press(1'b0, 1'b1, 12);
    expect_evt(3'd0, 1'b1, 1'b0); press(1'b0, 1'b1, 12);
    expect_evt(3'd1, 1'b0, 1'b0); press(1'b1, 1'b0, 12);

    // Both buttons with identical waveforms give coincident pulses; start wins.
    expect_evt(3'd2, 1'b0, 1'b0); press(1'b1, 1'b1, 12);
    expect_evt(3'd1, 1'b0, 1'b0); press(1'b1, 1'b0, 20);
    chk("run_before_rst", state, 1);

    // Asynchronous reset mid-RUN.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    chk_reset_outputs("mid_rst_hold");
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("after_mid_rst", state, 0);
    chk("after_mid_rst_clear", clear, 0);
    chk("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
